// File: rtl/pdu_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pdu_io_pkg
//  Description : Shared op encoding and PDU IO register map for the CPU-side
//                bus master, the PDU and software headers.
//  Revision    : 1.0  initial release
// ============================================================================
package pdu_io_pkg;

    typedef enum logic [1:0] {
        OP_SW_READ   = 2'd0,
        OP_SEG_WRITE = 2'd1,
        OP_BTN_READ  = 2'd2,
        OP_CNT_READ  = 2'd3
    } pdu_op_e;

    localparam logic [7:0] C_IO_BTN_RAW  = 8'h04;
    localparam logic [7:0] C_IO_SEG_RDY  = 8'h08;
    localparam logic [7:0] C_IO_SEG_DATA = 8'h0C;
    localparam logic [7:0] C_IO_SWX_VLD  = 8'h10;
    localparam logic [7:0] C_IO_SWX_DATA = 8'h14;
    localparam logic [7:0] C_IO_CNT_DATA = 8'h18;
    localparam logic [7:0] C_IO_BTN_VLD  = 8'h1C;
    localparam logic [7:0] C_IO_BTN_DATA = 8'h20;

    // The counter has no status register; its entry is never used for a poll.
    function automatic logic [7:0] status_addr(input pdu_op_e op);
        logic [7:0] w_addr;
        case (op)
            OP_SW_READ:   w_addr = C_IO_SWX_VLD;
            OP_SEG_WRITE: w_addr = C_IO_SEG_RDY;
            OP_BTN_READ:  w_addr = C_IO_BTN_VLD;
            default:      w_addr = 8'h00;
        endcase
        return w_addr;
    endfunction

    function automatic logic [7:0] data_addr(input pdu_op_e op);
        logic [7:0] w_addr;
        case (op)
            OP_SW_READ:   w_addr = C_IO_SWX_DATA;
            OP_SEG_WRITE: w_addr = C_IO_SEG_DATA;
            OP_BTN_READ:  w_addr = C_IO_BTN_DATA;
            default:      w_addr = C_IO_CNT_DATA;
        endcase
        return w_addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pdu_io_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : pdu_io_master_if
//  Description : Request/response channels and PDU IO bus of the bus master.
//  Revision    : 1.0  initial release
// ============================================================================
interface pdu_io_master_if;
    import pdu_io_pkg::*;

    logic        req_valid;
    logic        req_ready;
    pdu_op_e     req_op;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic        io_rd;
    logic [31:0] io_din;

    modport master (
        input  req_valid, req_op, req_wdata, rsp_ready, io_din,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output io_addr, io_dout, io_we, io_rd
    );

    modport slave (
        output req_valid, req_op, req_wdata, rsp_ready, io_din,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  io_addr, io_dout, io_we, io_rd
    );

endinterface
`default_nettype wire

// File: rtl/pdu_io_master.sv
`default_nettype none
// ============================================================================
//  Module      : pdu_io_master
//  Description : Runs one PDU request at a time: status poll, single data
//                access, then a held valid/ready response.
//  Revision    : 1.0  initial release
// ============================================================================
module pdu_io_master
    import pdu_io_pkg::*;
#(
    parameter int MAX_POLLS = 1000000,
    parameter int POLL_GAP  = 4
) (
    input  wire logic          clk,
    input  wire logic          rstn,
    pdu_io_master_if.master    bus
);

    localparam int CNT_W = $clog2(MAX_POLLS + 1);
    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [CNT_W-1:0] C_POLL_LAST = CNT_W'(MAX_POLLS - 1);
    localparam logic [GAP_W-1:0] C_GAP_LAST  = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POLL   = 3'd1,
        ST_GAP    = 3'd2,
        ST_ACCESS = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    state_e           r_state;
    pdu_op_e          r_op;
    logic [31:0]      r_wdata;
    logic [CNT_W-1:0] r_poll_cnt;
    logic [GAP_W-1:0] r_gap_cnt;

    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_data;
    logic             r_rsp_err;
    logic [7:0]       r_io_addr;
    logic [31:0]      r_io_dout;
    logic             r_io_we;
    logic             r_io_rd;

    // Bus outputs are registered with the state so strobes line up with POLL/ACCESS.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_SW_READ;
            r_wdata     <= '0;
            r_poll_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_io_addr   <= '0;
            r_io_dout   <= '0;
            r_io_we     <= 1'b0;
            r_io_rd     <= 1'b0;
        end else begin
            r_io_addr <= '0;
            r_io_dout <= '0;
            r_io_we   <= 1'b0;
            r_io_rd   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_op        <= bus.req_op;
                        r_wdata     <= bus.req_wdata;
                        r_poll_cnt  <= '0;
                        r_req_ready <= 1'b0;
                        r_io_rd     <= 1'b1;
                        if (bus.req_op == OP_CNT_READ) begin
                            r_state   <= ST_ACCESS;
                            r_io_addr <= C_IO_CNT_DATA;
                        end else begin
                            r_state   <= ST_POLL;
                            r_io_addr <= status_addr(bus.req_op);
                        end
                    end
                end

                ST_POLL: begin
                    r_poll_cnt <= r_poll_cnt + CNT_W'(1);
                    if (bus.io_din[0]) begin
                        r_state   <= ST_ACCESS;
                        r_io_addr <= data_addr(r_op);
                        if (r_op == OP_SEG_WRITE) begin
                            r_io_we   <= 1'b1;
                            r_io_dout <= r_wdata;
                        end else begin
                            r_io_rd   <= 1'b1;
                        end
                    end else if (r_poll_cnt == C_POLL_LAST) begin
                        // Timeout: respond without touching the data register.
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= '0;
                    end else if (POLL_GAP == 0) begin
                        r_io_addr <= status_addr(r_op);
                        r_io_rd   <= 1'b1;
                    end else begin
                        r_state   <= ST_GAP;
                        r_gap_cnt <= '0;
                    end
                end

                ST_GAP: begin
                    if (r_gap_cnt == C_GAP_LAST) begin
                        r_state   <= ST_POLL;
                        r_io_addr <= status_addr(r_op);
                        r_io_rd   <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end

                ST_ACCESS: begin
                    r_state     <= ST_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    case (r_op)
                        OP_SEG_WRITE: r_rsp_data <= '0;
                        OP_BTN_READ:  r_rsp_data <= {28'd0, bus.io_din[3:0]};
                        default:      r_rsp_data <= bus.io_din;
                    endcase
                end

                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.io_addr   = r_io_addr;
    assign bus.io_dout   = r_io_dout;
    assign bus.io_we     = r_io_we;
    assign bus.io_rd     = r_io_rd;

endmodule
`default_nettype wire

// File: tb/tb_pdu_io_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pdu_io_master
//  Description : Self-checking bench for pdu_io_master with a behavioural PDU
//                register file and an expected-response queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pdu_io_master;
    import pdu_io_pkg::*;

    localparam int MAX_POLLS = 8;
    localparam int POLL_GAP  = 4;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    logic clk;
    logic rstn;

    pdu_io_master_if bus ();

    pdu_io_master #(
        .MAX_POLLS (MAX_POLLS),
        .POLL_GAP  (POLL_GAP)
    ) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PDU register model
    logic        seg_rdy;
    logic [31:0] swx_data;
    logic [31:0] cnt_data;
    logic        btn_vld;
    logic [31:0] btn_data;
    int          sw_polls;

    always_comb begin
        bus.io_din = 32'h0;
        case (bus.io_addr)
            C_IO_SEG_RDY:  bus.io_din = {31'd0, seg_rdy};
            C_IO_SWX_VLD:  bus.io_din = {31'd0, (sw_polls >= 3)};
            C_IO_SWX_DATA: bus.io_din = swx_data;
            C_IO_CNT_DATA: bus.io_din = cnt_data;
            C_IO_BTN_VLD:  bus.io_din = {31'd0, btn_vld};
            C_IO_BTN_DATA: bus.io_din = btn_data;
            default:       bus.io_din = 32'h0;
        endcase
    end

    // Bus strobe monitor
    int          cyc;
    int          rd_cnt [256];
    int          rd_total;
    int          we_total;
    logic [7:0]  we_addr;
    logic [31:0] we_data;
    int          sw_t [$];

    initial begin
        cyc      = 0;
        rd_total = 0;
        we_total = 0;
        sw_polls = 0;
        we_addr  = 8'h0;
        we_data  = 32'h0;
        for (int i = 0; i < 256; i++) rd_cnt[i] = 0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn && bus.io_rd) begin
            rd_cnt[bus.io_addr] = rd_cnt[bus.io_addr] + 1;
            rd_total = rd_total + 1;
            if (bus.io_addr == C_IO_SWX_VLD) begin
                sw_polls = sw_polls + 1;
                sw_t.push_back(cyc);
            end
        end
        if (rstn && bus.io_we) begin
            we_total = we_total + 1;
            we_addr  = bus.io_addr;
            we_data  = bus.io_dout;
        end
    end

    int   n_chk;
    int   n_pass;
    exp_t sb [$];
    int   snap_rd [256];
    int   snap_rd_total;
    int   snap_we;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic snapshot();
        snap_rd       = rd_cnt;
        snap_rd_total = rd_total;
        snap_we       = we_total;
    endtask

    // Called right after an acceptance edge; returns at the negedge showing rsp_valid.
    task automatic wait_rsp(input string tag);
        int   lat;
        exp_t e;
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            check({tag, "_timeout"}, 32'd1, 32'd0);
            return;
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_lat"},  lat,         e.lat);
        check({tag, "_data"}, bus.rsp_data, e.data);
        check({tag, "_err"},  {31'd0, bus.rsp_err}, {31'd0, e.err});
    endtask

    task automatic do_req(input string tag, input pdu_op_e op, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        exp_t e;
        @(negedge clk);
        check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_wdata = wdata;
        @(posedge clk);
        e.data = exp_data;
        e.err  = exp_err;
        e.lat  = exp_lat;
        sb.push_back(e);
        #1;
        bus.req_valid = 1'b0;
        wait_rsp(tag);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_rsp_drop"}, {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        int base;
        n_chk         = 0;
        n_pass        = 0;
        rstn          = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_SW_READ;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b1;
        seg_rdy       = 1'b0;
        swx_data      = 32'h0;
        cnt_data      = 32'h0;
        btn_vld       = 1'b0;
        btn_data      = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_data",  bus.rsp_data, 32'd0);
        check("rst_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
        check("rst_io_addr",   {24'd0, bus.io_addr}, 32'd0);
        check("rst_io_dout",   bus.io_dout, 32'd0);
        check("rst_io_we",     {31'd0, bus.io_we}, 32'd0);
        check("rst_io_rd",     {31'd0, bus.io_rd}, 32'd0);
        rstn = 1'b1;

        // Counter read: no poll, single read of 0x18
        cnt_data = 32'h0000_1234;
        snapshot();
        do_req("cnt", OP_CNT_READ, 32'h0, 32'h0000_1234, 1'b0, 2);
        check("cnt_rd18",  rd_cnt[8'h18] - snap_rd[8'h18], 1);
        check("cnt_rdall", rd_total - snap_rd_total, 1);

        // Display write with ready already set
        seg_rdy = 1'b1;
        snapshot();
        do_req("seg", OP_SEG_WRITE, 32'hDEAD_BEEF, 32'h0, 1'b0, 3);
        check("seg_poll08", rd_cnt[8'h08] - snap_rd[8'h08], 1);
        check("seg_rdall",  rd_total - snap_rd_total, 1);
        check("seg_we_cnt", we_total - snap_we, 1);
        check("seg_we_addr", {24'd0, we_addr}, 32'h0C);
        check("seg_we_data", we_data, 32'hDEAD_BEEF);

        // Switch read: valid appears on the third poll
        swx_data = 32'hCAFE_F00D;
        snapshot();
        base = sw_t.size();
        do_req("sw", OP_SW_READ, 32'h0, 32'hCAFE_F00D, 1'b0, 3 + 2 * (1 + POLL_GAP));
        check("sw_polls",  rd_cnt[8'h10] - snap_rd[8'h10], 3);
        check("sw_rd14",   rd_cnt[8'h14] - snap_rd[8'h14], 1);
        if (sw_t.size() >= base + 3) begin
            check("sw_gap1", sw_t[base + 1] - sw_t[base],     1 + POLL_GAP);
            check("sw_gap2", sw_t[base + 2] - sw_t[base + 1], 1 + POLL_GAP);
        end

        // Button read, status stuck low: timeout after MAX_POLLS polls
        btn_vld  = 1'b0;
        btn_data = 32'h0000_000F;
        snapshot();
        do_req("btn_to", OP_BTN_READ, 32'h0, 32'h0, 1'b1,
               MAX_POLLS + (MAX_POLLS - 1) * POLL_GAP + 1);
        check("btn_to_polls", rd_cnt[8'h1C] - snap_rd[8'h1C], MAX_POLLS);
        check("btn_to_rd20",  rd_cnt[8'h20] - snap_rd[8'h20], 0);

        // Button read, only the low nibble is returned
        btn_vld  = 1'b1;
        btn_data = 32'hFFFF_FFA5;
        snapshot();
        do_req("btn", OP_BTN_READ, 32'h0, 32'h0000_0005, 1'b0, 3);
        check("btn_rd20", rd_cnt[8'h20] - snap_rd[8'h20], 1);

        // Response stall with a pending request held on req_valid
        begin
            exp_t e;
            cnt_data      = 32'h0000_55AA;
            bus.rsp_ready = 1'b0;
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_op    = OP_CNT_READ;
            @(posedge clk);
            e.data = 32'h0000_55AA; e.err = 1'b0; e.lat = 2;
            sb.push_back(e);
            #1;
            wait_rsp("stall1");
            cnt_data = 32'h0000_0077;
            repeat (10) begin
                @(negedge clk);
                check("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
                check("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
                check("stall_rsp_data",  bus.rsp_data, 32'h0000_55AA);
            end
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("stall_idle_ready", {31'd0, bus.req_ready}, 32'd1);
            check("stall_idle_valid", {31'd0, bus.rsp_valid}, 32'd0);
            @(posedge clk);
            e.data = 32'h0000_0077; e.err = 1'b0; e.lat = 2;
            sb.push_back(e);
            #1;
            check("stall_accept_next", {31'd0, bus.req_ready}, 32'd0);
            bus.req_valid = 1'b0;
            wait_rsp("stall2");
            @(posedge clk);
            @(negedge clk);
        end

        // Reset pulse during the GAP of a display write
        seg_rdy = 1'b0;
        snapshot();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_SEG_WRITE;
        bus.req_wdata = 32'h1357_9BDF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("arst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("arst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("arst_io_addr",   {24'd0, bus.io_addr}, 32'd0);
        check("arst_io_rd",     {31'd0, bus.io_rd}, 32'd0);
        check("arst_io_we",     {31'd0, bus.io_we}, 32'd0);
        repeat (2) @(negedge clk);
        rstn    = 1'b1;
        seg_rdy = 1'b1;
        repeat (20) @(negedge clk);
        check("arst_no_we",     we_total - snap_we, 0);
        check("arst_polls",     rd_cnt[8'h08] - snap_rd[8'h08], 1);
        check("arst_idle",      {31'd0, bus.req_ready}, 32'd1);

        // Normal operation after reset; switch status is already valid
        swx_data = 32'h8000_0001;
        do_req("post_rst", OP_SW_READ, 32'h0, 32'h8000_0001, 1'b0, 3);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
